// File: rtl/pyc_byte_mem_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : pyc_byte_mem_pipe
//  Purpose  : Byte-addressed memory with a valid/ready request channel, a
//             pipelined read path of RD_LATENCY register stages and an
//             in-order show-ahead response FIFO with backpressure. Every
//             accepted request (read or byte-strobed write) yields exactly
//             one response; out-of-range bytes raise resp_err.
//  Ports    : clk, rst          - clock, synchronous active-high reset
//             req_valid/ready   - request handshake
//             req_write         - 1 = write, 0 = read
//             req_addr          - byte address of lane 0
//             req_wdata/wstrb   - little-endian write data, byte enables
//             resp_valid/ready  - response handshake
//             resp_rdata        - read data (0 for write responses)
//             resp_err          - an addressed byte was out of range
//  Revision : 1.0 - initial release
// ============================================================================
module pyc_byte_mem_pipe #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 1024,
    parameter int RD_LATENCY = 1,
    parameter int RESP_DEPTH = 4,
    parameter     INIT_MEMH  = "",
    localparam int STRB_WIDTH = (DATA_WIDTH + 7) / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_wstrb,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    localparam int c_PAD_WIDTH = STRB_WIDTH * 8;
    localparam int c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_PTR_W     = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int c_CNT_W     = $clog2(RESP_DEPTH + 1);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("pyc_byte_mem_pipe: RD_LATENCY must be within 1..4");
    end
    if (RESP_DEPTH < 1) begin : g_bad_resp_depth
        $error("pyc_byte_mem_pipe: RESP_DEPTH must be at least 1");
    end
    if (INIT_MEMH != "") begin : g_init_memh
        $warning("pyc_byte_mem_pipe: INIT_MEMH preload is not performed in RTL; load contents through the request port");
    end

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [7:0]            r_mem [DEPTH];

    logic [RD_LATENCY-1:0] r_pipe_vld;
    logic [DATA_WIDTH-1:0] r_pipe_rdata [RD_LATENCY];
    logic [RD_LATENCY-1:0] r_pipe_err;

    logic [DATA_WIDTH-1:0] r_fifo_rdata [RESP_DEPTH];
    logic [RESP_DEPTH-1:0] r_fifo_err;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_fifo_cnt;
    logic [c_CNT_W-1:0]    r_outstanding;

    logic [DATA_WIDTH-1:0] r_last_rdata;
    logic                  r_last_err;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH:0]    w_lane_sum [STRB_WIDTH];
    logic [c_IDX_W-1:0]     w_lane_idx [STRB_WIDTH];
    logic [STRB_WIDTH-1:0]  w_lane_ok;
    logic [STRB_WIDTH-1:0]  w_addressed;
    logic [c_PAD_WIDTH-1:0] w_wdata_pad;
    logic [c_PAD_WIDTH-1:0] w_rd_pad;
    logic [DATA_WIDTH-1:0]  w_cap_rdata;
    logic                   w_cap_err;

    logic w_accept;
    logic w_pop;
    logic w_push;
    logic w_fifo_empty;

    // The lane address is formed one bit wider than the request address so
    // that an address near the top of the address space is never wrapped
    // back into the valid range.
    always_comb begin
        w_lane_ok   = '0;
        w_rd_pad    = '0;
        w_wdata_pad = '0;
        w_wdata_pad[DATA_WIDTH-1:0] = req_wdata;
        for (int l = 0; l < STRB_WIDTH; l++) begin
            w_lane_sum[l] = {1'b0, req_addr} + (ADDR_WIDTH + 1)'(l);
            w_lane_idx[l] = w_lane_sum[l][c_IDX_W-1:0];
            w_lane_ok[l]  = (w_lane_sum[l] < (ADDR_WIDTH + 1)'(DEPTH));
            w_rd_pad[l*8 +: 8] = w_lane_ok[l] ? r_mem[w_lane_idx[l]] : 8'h00;
        end
    end

    // Reads address every lane; writes address only strobed lanes.
    assign w_addressed = req_write ? req_wstrb : {STRB_WIDTH{1'b1}};
    assign w_cap_err   = |(w_addressed & ~w_lane_ok);
    assign w_cap_rdata = req_write ? '0 : w_rd_pad[DATA_WIDTH-1:0];

    // ------------------------------------------------------------------
    // Handshakes (ready/valid depend only on registered state and rst)
    // ------------------------------------------------------------------
    assign w_fifo_empty = (r_fifo_cnt == '0);
    assign req_ready    = !rst && (r_outstanding < c_CNT_W'(RESP_DEPTH));
    assign resp_valid   = !rst && !w_fifo_empty;
    assign w_accept     = req_valid && req_ready;
    assign w_pop        = resp_valid && resp_ready;
    assign w_push       = r_pipe_vld[RD_LATENCY-1];

    // When the FIFO is empty the outputs keep the last popped response.
    assign resp_rdata = rst ? '0 :
                        (w_fifo_empty ? r_last_rdata : r_fifo_rdata[r_rd_ptr]);
    assign resp_err   = rst ? 1'b0 :
                        (w_fifo_empty ? r_last_err : r_fifo_err[r_rd_ptr]);

    // ------------------------------------------------------------------
    // Memory write port (contents survive reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept && req_write) begin
            for (int l = 0; l < STRB_WIDTH; l++) begin
                if (req_wstrb[l] && w_lane_ok[l]) begin
                    r_mem[w_lane_idx[l]] <= w_wdata_pad[l*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline: stage 0 captures at accept, RD_LATENCY-1 more stages
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_vld <= '0;
        end else begin
            r_pipe_vld[0] <= w_accept;
            for (int s = 1; s < RD_LATENCY; s++) begin
                r_pipe_vld[s] <= r_pipe_vld[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pipe_rdata[0] <= w_cap_rdata;
            r_pipe_err[0]   <= w_cap_err;
        end
        for (int s = 1; s < RD_LATENCY; s++) begin
            r_pipe_rdata[s] <= r_pipe_rdata[s-1];
            r_pipe_err[s]   <= r_pipe_err[s-1];
        end
    end

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    function automatic logic [c_PTR_W-1:0] f_ptr_next(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rdata[r_wr_ptr] <= r_pipe_rdata[RD_LATENCY-1];
            r_fifo_err[r_wr_ptr]   <= r_pipe_err[RD_LATENCY-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_fifo_cnt    <= '0;
            r_outstanding <= '0;
            r_last_rdata  <= '0;
            r_last_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr     <= f_ptr_next(r_rd_ptr);
                r_last_rdata <= r_fifo_rdata[r_rd_ptr];
                r_last_err   <= r_fifo_err[r_rd_ptr];
            end

            case ({w_push, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase

            // Credits: an accept takes one, a pop returns one; both in the
            // same cycle cancel.
            case ({w_accept, w_pop})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pyc_byte_mem_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pyc_byte_mem_pipe
//  Purpose  : Self-checking bench for pyc_byte_mem_pipe. A transaction-level
//             model (byte array, response queue, credit count) predicts the
//             DUT outputs every cycle under directed and random stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pyc_byte_mem_pipe;

    localparam int c_DEPTH = 1024;
    localparam int c_LAT   = 2;
    localparam int c_RDEP  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    always #5 clk = ~clk;

    pyc_byte_mem_pipe #(
        .ADDR_WIDTH (64),
        .DATA_WIDTH (64),
        .DEPTH      (c_DEPTH),
        .RD_LATENCY (c_LAT),
        .RESP_DEPTH (c_RDEP),
        .INIT_MEMH  ("")
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    // ------------------------------------------------------------------
    // Reference model state
    // ------------------------------------------------------------------
    typedef struct {
        logic [63:0] rdata;
        logic        err;
        longint      t;      // edge count after which the response is visible
    } resp_t;

    resp_t       m_q[$];
    logic [7:0]  m_mem [c_DEPTH];
    int          m_outstanding = 0;
    longint      m_edges = 0;
    logic [63:0] m_last_rdata = '0;
    logic        m_last_err = 1'b0;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, m_edges);
        end
    endtask

    function automatic bit in_range(input logic [63:0] a, input int lane);
        return (a < 64'(c_DEPTH)) && ((a + 64'(lane)) < 64'(c_DEPTH));
    endfunction

    // One clock cycle: drive, check outputs, advance model across the edge.
    task automatic cycle(input bit r, input bit v, input bit w, input logic [63:0] a,
                         input logic [63:0] d, input logic [7:0] s, input bit rr,
                         output bit acc);
        bit          exp_ready;
        bit          exp_valid;
        bit          pop;
        logic [63:0] exp_rd;
        logic        exp_err;
        resp_t       e;

        rst = r; req_valid = v; req_write = w; req_addr = a;
        req_wdata = d; req_wstrb = s; resp_ready = rr;
        #1;
        exp_ready = !r && (m_outstanding < c_RDEP);
        exp_valid = !r && (m_q.size() > 0) && (m_edges >= m_q[0].t);
        exp_rd    = r ? 64'h0 : (exp_valid ? m_q[0].rdata : m_last_rdata);
        exp_err   = r ? 1'b0  : (exp_valid ? m_q[0].err   : m_last_err);
        check("req_ready",  64'(req_ready),  64'(exp_ready));
        check("resp_valid", 64'(resp_valid), 64'(exp_valid));
        check("resp_rdata", resp_rdata,      exp_rd);
        check("resp_err",   64'(resp_err),   64'(exp_err));

        acc = v && exp_ready;
        pop = exp_valid && rr;

        @(posedge clk);
        m_edges++;
        if (r) begin
            m_q.delete();
            m_outstanding = 0;
            m_last_rdata  = '0;
            m_last_err    = 1'b0;
        end else begin
            if (pop) begin
                m_last_rdata = m_q[0].rdata;
                m_last_err   = m_q[0].err;
                void'(m_q.pop_front());
                m_outstanding--;
            end
            if (acc) begin
                e.rdata = '0;
                e.err   = 1'b0;
                e.t     = m_edges + c_LAT;
                for (int l = 0; l < 8; l++) begin
                    if (!w) begin
                        if (in_range(a, l)) e.rdata[8*l +: 8] = m_mem[int'(a) + l];
                        else                e.err = 1'b1;
                    end else if (s[l]) begin
                        if (in_range(a, l)) m_mem[int'(a) + l] = d[8*l +: 8];
                        else                e.err = 1'b1;
                    end
                end
                m_q.push_back(e);
                m_outstanding++;
            end
        end
        @(negedge clk);
    endtask

    // Present a request until accepted, with a bounded number of tries.
    task automatic send(input bit w, input logic [63:0] a, input logic [63:0] d,
                        input logic [7:0] s, input bit rr);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 32 && !acc; i++) begin
            cycle(1'b0, 1'b1, w, a, d, s, rr, acc);
        end
        check("send_accepted", 64'(acc), 64'd1);
    endtask

    task automatic idle(input int n, input bit rr);
        bit acc;
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, rr, acc);
        end
    endtask

    initial begin
        bit          acc;
        bit          v;
        bit          w;
        bit          rr;
        bit          r;
        logic [63:0] a;

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_wstrb = '0; resp_ready = 1'b0;
        for (int i = 0; i < c_DEPTH; i++) m_mem[i] = 8'h00;
        @(negedge clk);

        // Reset, with a request presented that must not be accepted.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 64'h0, 64'hDEAD_BEEF_0000_0000, 8'hFF, 1'b1, acc);
        end

        // Give every byte a defined value.
        for (int i = 0; i < c_DEPTH / 8; i++) begin
            send(1'b1, 64'(i * 8), {$urandom, $urandom}, 8'hFF, 1'b1);
        end
        idle(6, 1'b1);

        // Write then read.
        send(1'b1, 64'h10, 64'h1122_3344_5566_7788, 8'hFF, 1'b1);
        send(1'b0, 64'h10, 64'h0, 8'h00, 1'b1);
        idle(4, 1'b1);

        // Partial strobe over a word of 0x11.
        send(1'b1, 64'h20, 64'h1111_1111_1111_1111, 8'hFF, 1'b1);
        send(1'b1, 64'h20, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 1'b1);
        send(1'b0, 64'h20, 64'h0, 8'h00, 1'b1);
        idle(4, 1'b1);

        // Range boundaries, including no wrap-around at the top of the space.
        send(1'b0, 64'd1020, 64'h0, 8'h00, 1'b1);
        send(1'b1, 64'd1020, 64'h0102_0304_A1B2_C3D4, 8'h0F, 1'b1);
        send(1'b0, 64'd1016, 64'h0, 8'h00, 1'b1);
        send(1'b0, 64'h1_0000_0000, 64'h0, 8'h00, 1'b1);
        send(1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 8'h00, 1'b1);
        send(1'b1, 64'h1_0000_0000, 64'h5555_5555_5555_5555, 8'h00, 1'b1);
        send(1'b1, 64'd1023, 64'hFFFF_FFFF_FFFF_FF5A, 8'h03, 1'b1);
        send(1'b0, 64'd1016, 64'h0, 8'h00, 1'b1);
        idle(5, 1'b1);

        // Backpressure: six reads with resp_ready low, then drain.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 64'(8 * i), 64'h0, 8'h00, 1'b0, acc);
        end
        send(1'b0, 64'h30, 64'h0, 8'h00, 1'b1);
        send(1'b0, 64'h38, 64'h0, 8'h00, 1'b1);
        idle(6, 1'b1);

        // Throughput: back-to-back reads with resp_ready held high.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 64'(16 * i), 64'h0, 8'h00, 1'b1, acc);
            check("throughput_accept", 64'(acc), 64'd1);
        end
        idle(5, 1'b1);

        // Reset while responses are in flight / buffered.
        send(1'b1, 64'h40, 64'hCAFE_F00D_1234_5678, 8'hFF, 1'b0);
        send(1'b0, 64'h48, 64'h0, 8'h00, 1'b0);
        send(1'b0, 64'h50, 64'h0, 8'h00, 1'b0);
        send(1'b0, 64'h58, 64'h0, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b1, acc);
        idle(4, 1'b1);
        send(1'b0, 64'h40, 64'h0, 8'h00, 1'b1);
        idle(4, 1'b1);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            v  = ($urandom_range(0, 9) < 7);
            w  = ($urandom_range(0, 9) < 4);
            rr = ($urandom_range(0, 9) < 7);
            r  = ($urandom_range(0, 199) == 0);
            case ($urandom_range(0, 9))
                0:       a = {32'h1, $urandom};
                1:       a = 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7));
                default: a = 64'($urandom_range(0, c_DEPTH + 8));
            endcase
            cycle(r, v, w, a, {$urandom, $urandom}, 8'($urandom), rr, acc);
        end
        idle(10, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
